// File: rtl/fibo_arb_pkg.sv
// Shared types and constants for the two-port Fibonacci calculator arbiter.
package fibo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int WDOG_W = 8;

endpackage

// File: rtl/fibo_arbiter_if.sv
// Requester handshake plus calculator START/DONE link, seen from both sides.
interface fibo_arbiter_if #(
  parameter int SIZE = 4
);
  logic            req0;
  logic            req1;
  logic [SIZE-1:0] count0;
  logic [SIZE-1:0] count1;
  logic            ack0;
  logic            ack1;
  logic            err;
  logic [SIZE-1:0] result;
  logic            calc_start;
  logic [SIZE-1:0] calc_count;
  logic            calc_done;
  logic [SIZE-1:0] calc_data;

  modport slave (
    input  req0, req1, count0, count1, calc_done, calc_data,
    output ack0, ack1, err, result, calc_start, calc_count
  );

  modport master (
    output req0, req1, count0, count1, calc_done, calc_data,
    input  ack0, ack1, err, result, calc_start, calc_count
  );
endinterface

// File: rtl/fibo_rr_pick.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the one not served last.
module fibo_rr_pick
  import fibo_arb_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  output logic grant_valid_o,
  output logic grant_id_o
);

  assign grant_valid_o = req0_i | req1_i;
  assign grant_id_o    = (req0_i & req1_i) ? ~last_i : req1_i;

endmodule

// File: rtl/fibo_arbiter.sv
// Shares one Fibonacci calculator between two requesters, with a watchdog on DONE.
module fibo_arbiter
  import fibo_arb_pkg::*;
#(
  parameter int SIZE    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  fibo_arbiter_if.slave bus
);

  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT);

  state_t            state_q;
  logic              owner_q;
  logic              last_q;
  logic              calc_start_q;
  logic              ack0_q;
  logic              ack1_q;
  logic              err_q;
  logic [SIZE-1:0]   calc_count_q;
  logic [SIZE-1:0]   result_q;
  logic [WDOG_W-1:0] wdog_q;
  logic [WDOG_W-1:0] wdog_d;
  logic              grant_valid;
  logic              grant_id;
  logic              done_ok;

  fibo_rr_pick u_pick (
    .req0_i        (bus.req0),
    .req1_i        (bus.req1),
    .last_i        (last_q),
    .grant_valid_o (grant_valid),
    .grant_id_o    (grant_id)
  );

  assign wdog_d  = (wdog_q == '1) ? wdog_q : wdog_q + 1'b1;
  // The first WAIT cycle still has wdog_q at 0; DONE seen there belongs to the previous job.
  assign done_ok = bus.calc_done && (wdog_q != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_q       <= 1'b1;
      calc_start_q <= 1'b0;
      calc_count_q <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      err_q        <= 1'b0;
      result_q     <= '0;
      wdog_q       <= '0;
    end else begin
      calc_start_q <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            owner_q      <= grant_id;
            calc_count_q <= grant_id ? bus.count1 : bus.count0;
            calc_start_q <= 1'b1;
            state_q      <= GRANT;
          end
        end
        GRANT: begin
          wdog_q  <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          wdog_q <= wdog_d;
          // An accepted DONE wins over a timeout landing in the same cycle.
          if (done_ok || (wdog_d >= WDOG_LIMIT)) begin
            result_q <= done_ok ? bus.calc_data : '0;
            err_q    <= ~done_ok;
            ack0_q   <= ~owner_q;
            ack1_q   <= owner_q;
            state_q  <= RESP;
          end
        end
        RESP: begin
          last_q  <= owner_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.calc_start = calc_start_q;
  assign bus.calc_count = calc_count_q;
  assign bus.ack0       = ack0_q;
  assign bus.ack1       = ack1_q;
  assign bus.err        = err_q;
  assign bus.result     = result_q;

endmodule

// File: doc/fibo_arbiter.md
# fibo_arbiter

Two-port round-robin arbiter that shares one Fibonacci calculator (START/count in, DONE/data_out back) between two independent requesters. It sits between the requesters and the calculator top. It latches the winner's count and pulses the calculator's START. It captures data_out on DONE and returns the result with a one-cycle acknowledge to the winner. A watchdog aborts a job whose DONE never arrives.

## Interface
- `size`, 4, width of count and result
- `TIMEOUT`, 64, maximum WAIT cycles before abort (1..255)

- `CLK`  in  1  single clock, all state on rising edge
- `RST`  in  1  reset, asynchronous, active-high
- `REQ0`, `REQ1`  in  1  job request, level; held until ACK
- `COUNT0`, `COUNT1`  in  size  job operand, stable while REQ high
- `ACK0`, `ACK1`  out  1  one-cycle completion pulse to requester n
- `ERR`  out  1  valid with ACK: 1 = job aborted by watchdog
- `RESULT`  out  size  last captured result, held until next completion
- `calc_start`  out  1  one-cycle START pulse to calculator
- `calc_count`  out  size  latched operand, stable from GRANT to RESP
- `calc_done`  in  1  calculator DONE, level
- `calc_data`  in  size  calculator data_out

## Operation
- States: IDLE, GRANT, WAIT, RESP.
- IDLE: if any REQ is high, pick the winner, latch its COUNT into `calc_count`, record the winner in `owner`, go to GRANT. Otherwise stay.
- Arbitration: one request wins outright. On a tie, the requester not served last wins. The `last` register resets to 1, so REQ0 wins the first tie.
- GRANT: `calc_start`=1 for exactly this cycle. Clear the watchdog. Go to WAIT.
- WAIT: `calc_done` is blanked in the first WAIT cycle (stale DONE from the previous job). From the second cycle, `calc_done`=1 captures `calc_data` into RESULT, sets ERR=0, goes to RESP.
- Watchdog in WAIT: increments each WAIT cycle. At TIMEOUT with no accepted DONE, RESULT=0, ERR=1, go to RESP.
- RESP: ACK[owner]=1 for one cycle. `last`←owner. Go to IDLE.
- Once latched, a job always completes. A requester dropping REQ after GRANT still gets its ACK. A REQ dropped before being sampled in IDLE is never served.
- The requester must drive REQ low in the cycle after its ACK. A REQ still high in that IDLE cycle is a new job.
- Reset, async at any time including mid-job:
  - state=IDLE; `calc_start`=0; `calc_count`=0
  - ACK0=ACK1=0; ERR=0; RESULT=0
  - `last`=1; watchdog=0
  - The calculator shares RST and is reset concurrently.

## Timing
- Cycle 0: IDLE samples REQ.
- Cycle 1: GRANT, `calc_start` high.
- Cycle 2: WAIT, done blanked.
- Cycle k≥3: WAIT accepts `calc_done`.
- Cycle k+1: RESP, ACK high, RESULT/ERR already updated.
- Cycle k+2: IDLE.
- Minimum issue-to-ACK latency is 4 cycles (REQ sample to ACK).
- Back-to-back jobs: one job per 5 cycles minimum.
- Timeout: ACK arrives in cycle 2+TIMEOUT.
- Watchdog is 8 bits and saturates; no wrap.
- All outputs are registered.

## Structure
- Package `fibo_arb_pkg`:
  - state encoding (2-bit IDLE=0, GRANT=1, WAIT=2, RESP=3)
  - watchdog width constant (8)
- Sub-module `fibo_rr_pick`: combinational two-way round-robin.
  - Inputs: REQ0, REQ1, `last`.
  - Outputs: `grant_valid`, `grant_id`.
- Top: FSM, operand/result registers, watchdog.

## Test plan
Bench uses a stub calculator that raises `calc_done` count+2 cycles after START and returns data=count+3.
- Single request: REQ0=1, COUNT0=5 → `calc_start` pulses in cycle 1, `calc_count`=5; ACK0 in RESP with RESULT=8, ERR=0; ACK1 never asserts.
- Simultaneous REQ0/REQ1 from reset: COUNT0=2, COUNT1=7 → requester 0 served first (RESULT=5, ACK0), then requester 1 (RESULT=10, ACK1); order alternates on the next tie.
- Stale DONE: stub holds `calc_done`=1 from the previous job until cycle 3 → RESULT is not captured in cycle 2; correct RESULT is returned afterwards.
- Timeout: stub never asserts DONE, TIMEOUT=8 → ACK at cycle 10, ERR=1, RESULT=0; next request is served normally.
- REQ dropped after GRANT: REQ1 deasserted in cycle 2 → ACK1 still pulses with the valid result.
- Reset mid-WAIT: RST pulsed asynchronously → all outputs 0 immediately, state IDLE, `last`=1; a fresh tie grants requester 0.
